// File: rtl/glm_dot.sv
// glm_dot: pairs sample lines from FIFO_input with model lines from MEM_model,
// reduces 16 signed Q-format lane products per line and writes one dot product per sample.
module glm_dot #(
  parameter int FRAC_BITS        = 16,
  parameter int LOG2_MEMORY_SIZE = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        op_start,
  output logic                        op_done,
  input  logic [31:0]                 regs [3],
  output logic                        FIFO_input_re,
  input  logic                        FIFO_input_rvalid,
  input  logic [511:0]                FIFO_input_rdata,
  input  logic                        FIFO_input_empty,
  output logic                        MEM_model_re,
  output logic [LOG2_MEMORY_SIZE-1:0] MEM_model_raddr,
  input  logic                        MEM_model_rvalid,
  input  logic [511:0]                MEM_model_rdata,
  output logic                        FIFO_dot_we,
  output logic [31:0]                 FIFO_dot_wdata,
  input  logic                        FIFO_dot_almostfull
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  logic internal_reset;

  state_t                      state_q;
  logic [31:0]                 nsamp_q;
  logic [31:0]                 lines_q;
  logic [LOG2_MEMORY_SIZE-1:0] base_q;
  logic [31:0]                 line_cnt_q;
  logic [31:0]                 sample_cnt_q;
  logic [31:0]                 wr_cnt_q;
  logic                        op_done_q;

  logic issue;
  logic last_line;
  logic last_sample;
  logic cfg_empty;

  logic unused_cfg;
  assign unused_cfg = ^regs[2][31:LOG2_MEMORY_SIZE];

  always_ff @(posedge clk) begin
    internal_reset <= reset;
  end

  // Issue is gated combinationally so a same-cycle empty/almostfull blocks it.
  assign issue       = (state_q == S_RUN) && !FIFO_input_empty && !FIFO_dot_almostfull;
  assign last_line   = (line_cnt_q == lines_q - 32'd1);
  assign last_sample = (sample_cnt_q == nsamp_q - 32'd1);
  assign cfg_empty   = (regs[0] == 32'd0) || (regs[1] == 32'd0);

  assign FIFO_input_re   = issue;
  assign MEM_model_re    = issue;
  assign MEM_model_raddr = base_q + line_cnt_q[LOG2_MEMORY_SIZE-1:0];
  assign op_done         = op_done_q;

  always_ff @(posedge clk) begin
    if (internal_reset) begin
      state_q      <= S_IDLE;
      nsamp_q      <= '0;
      lines_q      <= '0;
      base_q       <= '0;
      line_cnt_q   <= '0;
      sample_cnt_q <= '0;
      wr_cnt_q     <= '0;
      op_done_q    <= 1'b0;
    end else begin
      op_done_q <= 1'b0;
      if (FIFO_dot_we) begin
        wr_cnt_q <= wr_cnt_q + 32'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (op_start) begin
            nsamp_q      <= regs[0];
            lines_q      <= regs[1];
            base_q       <= regs[2][LOG2_MEMORY_SIZE-1:0];
            line_cnt_q   <= '0;
            sample_cnt_q <= '0;
            wr_cnt_q     <= '0;
            if (cfg_empty) begin
              state_q   <= S_DONE;
              op_done_q <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (issue) begin
            if (last_line) begin
              line_cnt_q   <= '0;
              sample_cnt_q <= sample_cnt_q + 32'd1;
              if (last_sample) begin
                state_q <= S_DRAIN;
              end
            end else begin
              line_cnt_q <= line_cnt_q + 32'd1;
            end
          end
        end
        S_DRAIN: begin
          // Count the write landing this cycle so op_done follows it by one cycle.
          if (wr_cnt_q + 32'(FIFO_dot_we) == nsamp_q) begin
            state_q   <= S_DONE;
            op_done_q <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Tag pipeline: 0 issue echo, 1 aligned pair, 2 products, 3..6 adder tree, 7 accumulator.
  logic [7:0] vld_q, vld_d;
  logic [7:0] first_q, first_d;
  logic [7:0] last_q, last_d;

  assign vld_d[0]   = issue;
  assign first_d[0] = (line_cnt_q == 32'd0);
  assign last_d[0]  = last_line;
  assign vld_d[1]   = vld_q[0] & FIFO_input_rvalid;
  assign first_d[1] = first_q[0];
  assign last_d[1]  = last_q[0];
  assign vld_d[2]   = vld_q[1] & MEM_model_rvalid;
  assign first_d[2] = first_q[1];
  assign last_d[2]  = last_q[1];

  for (genvar gi = 3; gi < 8; gi++) begin : g_tag
    assign vld_d[gi]   = vld_q[gi-1];
    assign first_d[gi] = first_q[gi-1];
    assign last_d[gi]  = last_q[gi-1];
  end

  logic [511:0]      smp_q;
  logic [15:0][63:0] prod_d, prod_q;
  logic [7:0][63:0]  l1_d, l1_q;
  logic [3:0][63:0]  l2_d, l2_q;
  logic [1:0][63:0]  l3_d, l3_q;
  logic [63:0]       l4_d, l4_q;
  logic [63:0]       acc_q;
  logic              we_q;
  logic [31:0]       wdata_q;

  for (genvar gi = 0; gi < 16; gi++) begin : g_mul
    logic [31:0] a_lane;
    logic [31:0] b_lane;
    assign a_lane     = smp_q[32*gi +: 32];
    assign b_lane     = MEM_model_rdata[32*gi +: 32];
    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign prod_d[gi] = {{32{a_lane[31]}}, a_lane} * {{32{b_lane[31]}}, b_lane};
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_l1
    assign l1_d[gi] = prod_q[2*gi] + prod_q[2*gi+1];
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_l2
    assign l2_d[gi] = l1_q[2*gi] + l1_q[2*gi+1];
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_l3
    assign l3_d[gi] = l2_q[2*gi] + l2_q[2*gi+1];
  end

  assign l4_d = l3_q[0] + l3_q[1];

  always_ff @(posedge clk) begin
    smp_q  <= FIFO_input_rdata;
    prod_q <= prod_d;
    l1_q   <= l1_d;
    l2_q   <= l2_d;
    l3_q   <= l3_d;
    l4_q   <= l4_d;
  end

  always_ff @(posedge clk) begin
    if (internal_reset) begin
      vld_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
      acc_q   <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      vld_q   <= vld_d;
      first_q <= first_d;
      last_q  <= last_d;
      if ((state_q == S_IDLE) && op_start) begin
        acc_q <= '0;
      end else if (vld_q[6]) begin
        acc_q <= first_q[6] ? l4_q : acc_q + l4_q;
      end
      we_q    <= vld_q[7] & last_q[7];
      wdata_q <= acc_q[FRAC_BITS+31:FRAC_BITS];
    end
  end

  assign FIFO_dot_we    = we_q;
  assign FIFO_dot_wdata = wdata_q;

endmodule

// File: tb/tb_glm_dot.sv
// Directed bench for glm_dot: table of instructions with hand-computed dot products,
// plus hand-written reset-during-run sequence.
module tb_glm_dot;
  localparam int L = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         op_start;
  logic         op_done;
  logic [31:0]  regs [3];
  logic         FIFO_input_re;
  logic         in_rvalid;
  logic [511:0] in_rdata;
  logic         empty;
  logic         MEM_model_re;
  logic [L-1:0] MEM_model_raddr;
  logic         mem_rvalid;
  logic [511:0] mem_rdata;
  logic         FIFO_dot_we;
  logic [31:0]  FIFO_dot_wdata;
  logic         almostfull;

  always #5 clk = ~clk;

  glm_dot #(.FRAC_BITS(16), .LOG2_MEMORY_SIZE(L)) dut (
    .clk                 (clk),
    .reset               (reset),
    .op_start            (op_start),
    .op_done             (op_done),
    .regs                (regs),
    .FIFO_input_re       (FIFO_input_re),
    .FIFO_input_rvalid   (in_rvalid),
    .FIFO_input_rdata    (in_rdata),
    .FIFO_input_empty    (empty),
    .MEM_model_re        (MEM_model_re),
    .MEM_model_raddr     (MEM_model_raddr),
    .MEM_model_rvalid    (mem_rvalid),
    .MEM_model_rdata     (mem_rdata),
    .FIFO_dot_we         (FIFO_dot_we),
    .FIFO_dot_wdata      (FIFO_dot_wdata),
    .FIFO_dot_almostfull (almostfull)
  );

  // Sample line n: every lane = s_val + n*s_step, odd lanes negated when s_alt.
  // Model line at address a: every lane = m_val + a*m_step.
  logic [31:0] s_val, s_step, m_val, m_step;
  bit          s_alt;

  function automatic logic [511:0] sample_line(input int unsigned n);
    logic [511:0] r;
    logic [31:0]  v;
    v = s_val + 32'(n) * s_step;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = (s_alt && (i % 2 == 1)) ? -v : v;
    return r;
  endfunction

  function automatic logic [511:0] model_line(input logic [L-1:0] a);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = m_val + 32'(a) * m_step;
    return r;
  endfunction

  int unsigned  line_ptr;
  logic         m_re_d;
  logic [L-1:0] m_addr_d;

  always @(posedge clk) begin
    if (reset) begin
      line_ptr   <= 0;
      in_rvalid  <= 1'b0;
      m_re_d     <= 1'b0;
      mem_rvalid <= 1'b0;
    end else begin
      in_rvalid <= FIFO_input_re;
      if (FIFO_input_re) begin
        in_rdata <= sample_line(line_ptr);
        line_ptr <= line_ptr + 1;
      end
      m_re_d     <= MEM_model_re;
      m_addr_d   <= MEM_model_raddr;
      mem_rvalid <= m_re_d;
      mem_rdata  <= model_line(m_addr_d);
    end
  end

  int           cyc = 0;
  int           re_cnt, we_cnt, done_cnt, viol;
  int           start_cyc, first_re_cyc, done_cyc;
  logic [L-1:0] raddr_log [64];
  logic [31:0]  wlog [16];
  int           wcyc [16];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      re_cnt       <= 0;
      we_cnt       <= 0;
      done_cnt     <= 0;
      viol         <= 0;
      start_cyc    <= -1;
      first_re_cyc <= -1;
      done_cyc     <= -1;
    end else begin
      if (op_start && start_cyc < 0) start_cyc <= cyc;
      if (FIFO_input_re) begin
        if (re_cnt == 0) first_re_cyc <= cyc;
        if (re_cnt < 64) raddr_log[re_cnt] <= MEM_model_raddr;
        re_cnt <= re_cnt + 1;
        if (empty || almostfull || !MEM_model_re) viol <= viol + 1;
      end else if (MEM_model_re) begin
        viol <= viol + 1;
      end
      if (FIFO_dot_we) begin
        if (we_cnt < 16) begin
          wlog[we_cnt] <= FIFO_dot_wdata;
          wcyc[we_cnt] <= cyc;
        end
        we_cnt <= we_cnt + 1;
        $display("write %0d: wdata=%08h at cycle %0d", we_cnt, FIFO_dot_wdata, cyc);
      end
      if (op_done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
    end
  end

  typedef struct {
    int unsigned      nsamp;
    int unsigned      lines;
    int unsigned      base;
    logic [31:0]      s_val;
    logic [31:0]      s_step;
    bit               s_alt;
    logic [31:0]      m_val;
    logic [31:0]      m_step;
    int               mode;     // 0 free-run, 1 almostfull window, 2 empty toggling, 3 ignored restart
    bit               chk_lat;
    bit               chk_addr;
    logic [3:0][31:0] exp;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic set_vec(input int idx, input int unsigned ns, input int unsigned ln,
                         input int unsigned base, input logic [31:0] sv, input logic [31:0] ss,
                         input bit alt, input logic [31:0] mv, input logic [31:0] ms,
                         input int mode, input bit lat, input bit adr,
                         input logic [31:0] e0, input logic [31:0] e1,
                         input logic [31:0] e2, input logic [31:0] e3);
    vecs[idx].nsamp    = ns;
    vecs[idx].lines    = ln;
    vecs[idx].base     = base;
    vecs[idx].s_val    = sv;
    vecs[idx].s_step   = ss;
    vecs[idx].s_alt    = alt;
    vecs[idx].m_val    = mv;
    vecs[idx].m_step   = ms;
    vecs[idx].mode     = mode;
    vecs[idx].chk_lat  = lat;
    vecs[idx].chk_addr = adr;
    vecs[idx].exp      = {e3, e2, e1, e0};
  endtask

  task automatic run_vec(input int idx, input bit do_reset);
    vec_t        v;
    int          t;
    int          af_left;
    int unsigned ea;
    v = vecs[idx];
    if (do_reset) apply_reset();
    s_val  = v.s_val;
    s_step = v.s_step;
    s_alt  = v.s_alt;
    m_val  = v.m_val;
    m_step = v.m_step;
    regs[0] = v.nsamp;
    regs[1] = v.lines;
    regs[2] = v.base;
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    af_left = 20;
    t = 0;
    while (done_cnt == 0 && t < 400) begin
      tick();
      t++;
      empty = (v.mode == 2) ? (t % 2 == 1) : 1'b0;
      if (v.mode == 1 && re_cnt >= 3 && af_left > 0) begin
        almostfull = 1'b1;
        af_left--;
      end else begin
        almostfull = 1'b0;
      end
      if (v.mode == 3 && t == 4) begin
        regs[0]  = 32'd1;
        op_start = 1'b1;
      end else begin
        op_start = 1'b0;
      end
    end
    empty      = 1'b0;
    almostfull = 1'b0;
    op_start   = 1'b0;
    check($sformatf("v%0d_timeout", idx), 64'(done_cnt == 0), 64'd0);
    repeat (15) tick();
    $display("vec %0d: nsamp=%0d lines=%0d base=%0d mode=%0d reads=%0d writes=%0d",
             idx, v.nsamp, v.lines, v.base, v.mode, re_cnt, we_cnt);
    check($sformatf("v%0d_done_count", idx), 64'(done_cnt), 64'd1);
    check($sformatf("v%0d_write_count", idx), 64'(we_cnt), 64'(v.nsamp * (v.lines != 0)));
    check($sformatf("v%0d_read_count", idx), 64'(re_cnt), 64'(v.nsamp * v.lines));
    check($sformatf("v%0d_gating", idx), 64'(viol), 64'd0);
    if (v.mode == 1) check($sformatf("v%0d_af_window", idx), 64'(af_left), 64'd0);
    if (v.nsamp == 0 || v.lines == 0) begin
      check($sformatf("v%0d_done_latency", idx), 64'(done_cyc - start_cyc), 64'd1);
    end else begin
      for (int k = 0; k < int'(v.nsamp) && k < 4; k++)
        check($sformatf("v%0d_result%0d", idx, k), 64'(wlog[k]), 64'(v.exp[k]));
      check($sformatf("v%0d_done_after_we", idx), 64'(done_cyc - wcyc[v.nsamp-1]), 64'd1);
      if (v.chk_lat)
        check($sformatf("v%0d_issue_to_we", idx), 64'(wcyc[0] - first_re_cyc), 64'd9);
      if ((v.mode == 0 || v.mode == 3) && v.nsamp > 1)
        for (int k = 1; k < int'(v.nsamp) && k < 4; k++)
          check($sformatf("v%0d_spacing%0d", idx, k), 64'(wcyc[k] - wcyc[k-1]), 64'(v.lines));
      if (v.chk_addr)
        for (int k = 0; k < re_cnt && k < 64; k++) begin
          ea = (v.base + (k % v.lines)) % (1 << L);
          check($sformatf("v%0d_raddr%0d", idx, k), 64'(raddr_log[k]), 64'(ea));
        end
    end
  endtask

  initial begin
    int t;
    reset      = 1'b1;
    op_start   = 1'b0;
    empty      = 1'b0;
    almostfull = 1'b0;
    regs[0] = '0;
    regs[1] = '0;
    regs[2] = '0;

    //       idx ns ln base s_val         s_step        alt m_val         m_step       mode lat adr  expected results
    set_vec(0, 1, 1, 0,   32'h0001_0000, 32'h0,         0, 32'h0002_0000, 32'h0,         0, 1, 1, 32'h0020_0000, 0, 0, 0);
    set_vec(1, 2, 3, 5,   32'h0001_0000, 32'h0,         1, 32'h0003_0000, 32'h0,         0, 0, 1, 32'h0, 32'h0, 0, 0);
    set_vec(2, 4, 2, 0,   32'h0001_0000, 32'h0001_0000, 0, 32'h0000_8000, 32'h0,         1, 0, 0,
            32'h0018_0000, 32'h0038_0000, 32'h0058_0000, 32'h0078_0000);
    set_vec(3, 4, 2, 0,   32'h0001_0000, 32'h0001_0000, 0, 32'h0000_8000, 32'h0,         2, 0, 0,
            32'h0018_0000, 32'h0038_0000, 32'h0058_0000, 32'h0078_0000);
    set_vec(4, 4, 2, 0,   32'h0001_0000, 32'h0001_0000, 0, 32'h0000_8000, 32'h0,         3, 0, 1,
            32'h0018_0000, 32'h0038_0000, 32'h0058_0000, 32'h0078_0000);
    set_vec(5, 1, 1, 0,   32'hFFFF_FFFF, 32'h0,         0, 32'h0000_0001, 32'h0,         0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0);
    set_vec(6, 1, 1, 0,   32'h7FFF_FFFF, 32'h0,         0, 32'h7FFF_FFFF, 32'h0,         0, 0, 0, 32'hFFF0_0000, 0, 0, 0);
    set_vec(7, 1, 2, 255, 32'h0001_0000, 32'h0,         0, 32'h0001_0000, 32'h0001_0000, 0, 0, 1, 32'h1010_0000, 0, 0, 0);
    set_vec(8, 0, 3, 0,   32'h0001_0000, 32'h0,         0, 32'h0001_0000, 32'h0,         0, 0, 0, 0, 0, 0, 0);
    set_vec(9, 2, 0, 0,   32'h0001_0000, 32'h0,         0, 32'h0001_0000, 32'h0,         0, 0, 0, 0, 0, 0, 0);

    apply_reset();
    check("reset_op_done", 64'(op_done), 64'd0);
    check("reset_in_re", 64'(FIFO_input_re), 64'd0);
    check("reset_mem_re", 64'(MEM_model_re), 64'd0);
    check("reset_we", 64'(FIFO_dot_we), 64'd0);

    for (int i = 0; i < NV; i++) run_vec(i, 1'b1);

    // Reset while lines are in flight, then a clean single-line instruction.
    apply_reset();
    s_val  = 32'h0001_0000;
    s_step = 32'h0;
    s_alt  = 1'b0;
    m_val  = 32'h0002_0000;
    m_step = 32'h0;
    regs[0] = 32'd2;
    regs[1] = 32'd4;
    regs[2] = 32'd0;
    op_start = 1'b1;
    tick();
    op_start = 1'b0;
    t = 0;
    while (re_cnt < 3 && t < 50) begin
      tick();
      t++;
    end
    check("midreset_reads_started", 64'(re_cnt >= 3), 64'd1);
    reset = 1'b1;
    empty = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    empty = 1'b0;
    repeat (30) tick();
    $display("mid-op reset: writes=%0d done=%0d reads=%0d after reset", we_cnt, done_cnt, re_cnt);
    check("midreset_no_we", 64'(we_cnt), 64'd0);
    check("midreset_no_done", 64'(done_cnt), 64'd0);
    check("midreset_idle", 64'(re_cnt), 64'd0);
    run_vec(0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
